// File: rtl/serial_nibble_adder.sv
// Multi-cycle wide adder: one 4-bit carry-lookahead slice per clock,
// LSB nibble first, with a valid/ready handshake on both sides.
module serial_nibble_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES:0]   out_sum,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    work;
    logic [W-1:0]    work_next;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [4:0]      s;
    logic            accept;
    logic            last;

    // 4-bit generate/propagate lookahead slice; returns {cout, sum}
    function automatic logic [4:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign accept    = in_valid & in_ready;
    assign last      = (idx == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Select the current operand nibbles and merge the new sum nibble
    always_comb begin
        a_nib     = 4'd0;
        b_nib     = 4'd0;
        work_next = work;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_q[i*4 +: 4];
                b_nib = b_q[i*4 +: 4];
            end
        end
        s = cla4(a_nib, b_nib, carry);
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                work_next[i*4 +: 4] = s[3:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (last) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            carry   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work    <= '0;
            out_sum <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                carry <= in_cin;
                idx   <= '0;
                work  <= '0;
            end
        end else if (state == RUN) begin
            work  <= work_next;
            carry <= s[4];
            if (last) begin
                idx     <= '0;
                out_sum <= {s[4], work_next};
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed self-checking bench for serial_nibble_adder (NIBBLES=4).
// Inputs driven and outputs sampled on the falling edge.
module tb_serial_nibble_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_sum;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_nibble_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [16:0] obs,
                       input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request and hold it until the accept edge, then drop it
    task automatic start(input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
        int n;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        in_cin   = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check latency and sum
    task automatic finish_op(input string tag, input logic [16:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            chk({tag, "_busy"}, {16'd0, busy}, 17'd1);
            step();
            n++;
        end
        chk({tag, "_lat"}, 17'(n), 17'd4);
        chk({tag, "_sum"}, out_sum, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;

        // 1: reset values
        repeat (3) step();
        chk("rst_valid", {16'd0, out_valid}, 17'd0);
        chk("rst_sum", out_sum, 17'd0);
        chk("rst_busy", {16'd0, busy}, 17'd0);
        chk("rst_ready", {16'd0, in_ready}, 17'd1);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_busy", {16'd0, busy}, 17'd0);
        chk("idle_ready", {16'd0, in_ready}, 17'd1);
        chk("idle_valid", {16'd0, out_valid}, 17'd0);

        // 2: basic add, latency, return to IDLE
        start(16'h1234, 16'h4321, 1'b0);
        chk("t2_inrdy_run", {16'd0, in_ready}, 17'd0);
        finish_op("t2", 17'h05555);
        step();
        chk("t2_inrdy_back", {16'd0, in_ready}, 17'd1);
        chk("t2_valid_drop", {16'd0, out_valid}, 17'd0);
        chk("t2_sum_hold", out_sum, 17'h05555);

        // 3: carry ripples through all nibbles
        start(16'hFFFF, 16'h0001, 1'b0);
        finish_op("t3", 17'h10000);
        step();

        // 4: carry-in cases
        start(16'hFFFF, 16'hFFFF, 1'b1);
        finish_op("t4a", 17'h1FFFF);
        step();
        start(16'h0000, 16'h0000, 1'b1);
        finish_op("t4b", 17'h00001);
        step();

        // 5: back-pressure with a pending request
        out_ready = 1'b0;
        start(16'h1111, 16'h2222, 1'b0);
        finish_op("t5a", 17'h03333);
        in_a     = 16'h0F0F;
        in_b     = 16'h00F1;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_hold_sum", out_sum, 17'h03333);
            chk("t5_hold_valid", {16'd0, out_valid}, 17'd1);
            chk("t5_hold_inrdy", {16'd0, in_ready}, 17'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_idle_inrdy", {16'd0, in_ready}, 17'd1);
        step();
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        chk("t5_accepted", {16'd0, busy}, 17'd1);
        finish_op("t5b", 17'h01000);
        out_ready = 1'b1;
        step();

        // 6: reset during the second RUN cycle
        start(16'hAAAA, 16'h5555, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_busy", {16'd0, busy}, 17'd0);
        chk("t6_inrdy", {16'd0, in_ready}, 17'd1);
        chk("t6_sum", out_sum, 17'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_no_valid", {16'd0, out_valid}, 17'd0);
        end
        start(16'h8000, 16'h8000, 1'b0);
        finish_op("t6b", 17'h10000);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
